// File: rtl/chip_ctrl_pkg.sv
// Shared definitions for the chip-control APB register file: register offsets,
// FSM/pad-select enums and mask helpers.
package chip_ctrl_pkg;

   localparam logic [15:0] INFO_VERSION = 16'h0001;

   localparam logic [11:0] REG_INFO    = 12'h000;
   localparam logic [11:0] REG_SCRATCH = 12'h004;
   localparam logic [11:0] REG_LOCK    = 12'h008;
   localparam logic [11:0] REG_CLKDIV  = 12'h00C;
   localparam logic [11:0] REG_BYPASS  = 12'h010;
   localparam logic [11:0] REG_PADMUX  = 12'h100;

   typedef enum logic [1:0] {
      PADMUX_GPIO = 2'd0,
      PADMUX_ALT1 = 2'd1,
      PADMUX_ALT2 = 2'd2,
      PADMUX_ALT3 = 2'd3
   } padmux_sel_e;

   typedef enum logic [1:0] {
      FSM_IDLE     = 2'd0,
      FSM_REQ      = 2'd1,
      FSM_DONE_OK  = 2'd2,
      FSM_DONE_ERR = 2'd3
   } apb_fsm_e;

   typedef struct packed {
      logic src;
      logic val;
   } bypass_t;

   // Bits of PADMUX word 'word' that map onto an existing pad.
   function automatic logic [31:0] padmux_word_mask(input int unsigned nb_pads,
                                                    input int unsigned word);
      logic [31:0] m;
      m = '0;
      for (int unsigned j = 0; j < 32; j++) begin
         if ((32 * word) + j < 2 * nb_pads) m[j] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/chip_ctrl_clkdiv_hs.sv
// Clock-divider req/ack handshake: REQ/DONE sequencing, timeout counter and
// the applied-value register that survives a failed or aborted request.
module chip_ctrl_clkdiv_hs
   import chip_ctrl_pkg::*;
#(
   parameter int unsigned DIV_WIDTH      = 8,
   parameter int unsigned DIV_RESET      = 1,
   parameter int unsigned CLKGEN_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] value_in,
   input  logic                 abort,
   input  logic                 ack,
   output logic                 req,
   output logic                 done,
   output logic                 err,
   output logic [DIV_WIDTH-1:0] value,
   output logic [DIV_WIDTH-1:0] applied
);

   localparam int unsigned CNT_W = (CLKGEN_TIMEOUT > 1) ? $clog2(CLKGEN_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKGEN_TIMEOUT - 1);

   apb_fsm_e             state;
   logic [CNT_W-1:0]     cnt;
   logic [DIV_WIDTH-1:0] pending;

   // Ack beats the terminal count; a dropped psel aborts without touching applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FSM_IDLE;
         cnt     <= '0;
         pending <= DIV_WIDTH'(DIV_RESET);
         applied <= DIV_WIDTH'(DIV_RESET);
      end else begin
         case (state)
            FSM_IDLE: begin
               if (start) begin
                  state   <= FSM_REQ;
                  cnt     <= '0;
                  pending <= value_in;
               end
            end
            FSM_REQ: begin
               if (abort) begin
                  state <= FSM_IDLE;
               end else if (ack) begin
                  state   <= FSM_DONE_OK;
                  applied <= pending;
               end else if (cnt == CNT_LAST) begin
                  state <= FSM_DONE_ERR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= FSM_IDLE;
         endcase
      end
   end

   assign req   = (state == FSM_REQ);
   assign done  = (state == FSM_DONE_OK);
   assign err   = (state == FSM_DONE_ERR);
   assign value = req ? pending : applied;

endmodule

// File: rtl/chip_ctrl_apb_regfile.sv
// Chip-control APB3 register file: pad mux, clock-divider handshake, FLL bypass
// and sticky lock. Optional per-byte strobes under `CHIP_CTRL_APB_PSTRB_EN.
module chip_ctrl_apb_regfile
   import chip_ctrl_pkg::*;
#(
   parameter int unsigned NB_PADS        = 48,
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned DIV_WIDTH      = 8,
   parameter int unsigned DIV_RESET      = 1,
   parameter int unsigned CLKGEN_TIMEOUT = 255
) (
   input  logic                      soc_clk_i,
   input  logic                      soc_rstn_synced_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic [2:0]                pprot_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [31:0]               pwdata_i,
   input  logic [3:0]                pstrb_i,
   output logic [31:0]               prdata_o,
   output logic                      pready_o,
   output logic                      pslverr_o,
   output logic [2*NB_PADS-1:0]      padmux_o,
   output logic                      clkdiv_req_o,
   output logic [DIV_WIDTH-1:0]      clkdiv_value_o,
   input  logic                      clkdiv_ack_i,
   input  logic                      jtag_bypass_fll_i,
   output logic                      fll_bypass_o,
   output logic                      locked_o
);

   localparam int unsigned NB_PM_WORDS = (NB_PADS + 15) / 16;
   localparam int unsigned PM_BITS     = 32 * NB_PM_WORDS;
   localparam int unsigned WORD_W      = APB_ADDR_WIDTH - 2;

   logic                               access;
   logic [WORD_W-1:0]                  word;
   logic                               hit_info, hit_scratch, hit_lock;
   logic                               hit_clkdiv, hit_bypass, hit_pm;
   logic [NB_PM_WORDS-1:0]             pm_hit;
   logic [31:0]                        pm_rdata;
   logic [NB_PM_WORDS-1:0][31:0]       pm_wmask;
   logic                               decode_err, lock_err, idle, wr_en, start;
   logic [31:0]                        wmask;
   logic [31:0]                        rdata;
   logic [DIV_WIDTH-1:0]               div_next;

   logic [31:0]                        scratch_q;
   logic                               locked_q;
   bypass_t                            bypass_q;
   logic [NB_PM_WORDS-1:0][31:0]       padmux_q;
   logic [PM_BITS-1:0]                 padmux_flat;

   logic                               hs_req, hs_done, hs_err;
   logic [DIV_WIDTH-1:0]               hs_applied;

   logic                               unused_bits;
   assign unused_bits = ^{pprot_i, pstrb_i, paddr_i[1:0]};

   assign access = psel_i & penable_i;
   assign word   = paddr_i[APB_ADDR_WIDTH-1:2];

   assign hit_info    = (word == WORD_W'(REG_INFO >> 2));
   assign hit_scratch = (word == WORD_W'(REG_SCRATCH >> 2));
   assign hit_lock    = (word == WORD_W'(REG_LOCK >> 2));
   assign hit_clkdiv  = (word == WORD_W'(REG_CLKDIV >> 2));
   assign hit_bypass  = (word == WORD_W'(REG_BYPASS >> 2));

   always_comb begin
      pm_hit   = '0;
      pm_rdata = '0;
      for (int unsigned k = 0; k < NB_PM_WORDS; k++) begin
         pm_hit[k] = (word == WORD_W'((REG_PADMUX >> 2) + 12'(k)));
         if (pm_hit[k]) pm_rdata = pm_rdata | padmux_q[k];
      end
   end
   assign hit_pm = |pm_hit;

`ifdef CHIP_CTRL_APB_PSTRB_EN
   assign wmask = strobe_mask(pstrb_i);
`else
   assign wmask = '1;
`endif

   assign decode_err = ~(hit_info | hit_scratch | hit_lock | hit_clkdiv | hit_bypass | hit_pm);
   assign lock_err   = locked_q & pwrite_i & (hit_lock | hit_clkdiv | hit_bypass | hit_pm);
   assign idle       = ~(hs_req | hs_done | hs_err);
   assign wr_en      = idle & access & pwrite_i & ~decode_err & ~lock_err;
   assign start      = wr_en & hit_clkdiv & wmask[0];

   // Unstrobed divider bytes keep the currently applied value.
   always_comb begin
      div_next = hs_applied;
      for (int unsigned i = 0; i < DIV_WIDTH; i++) begin
         if (wmask[i]) div_next[i] = pwdata_i[i];
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NB_PM_WORDS; k++) begin
         pm_wmask[k] = (wr_en & pm_hit[k]) ? (wmask & padmux_word_mask(NB_PADS, k)) : 32'h0;
      end
   end

   always_ff @(posedge soc_clk_i or negedge soc_rstn_synced_i) begin
      if (!soc_rstn_synced_i) begin
         scratch_q    <= '0;
         locked_q     <= 1'b0;
         bypass_q.val <= 1'b0;
         bypass_q.src <= 1'b1;
         padmux_q     <= '0;
      end else begin
         if (wr_en & hit_scratch) begin
            scratch_q <= (scratch_q & ~wmask) | (pwdata_i & wmask);
         end
         if (wr_en & hit_lock & wmask[0] & pwdata_i[0]) begin
            locked_q <= 1'b1;
         end
         if (wr_en & hit_bypass & wmask[0]) begin
            bypass_q.val <= pwdata_i[0];
            bypass_q.src <= pwdata_i[1];
         end
         for (int unsigned k = 0; k < NB_PM_WORDS; k++) begin
            padmux_q[k] <= (padmux_q[k] & ~pm_wmask[k]) | (pwdata_i & pm_wmask[k]);
         end
      end
   end

   chip_ctrl_clkdiv_hs #(
      .DIV_WIDTH      (DIV_WIDTH),
      .DIV_RESET      (DIV_RESET),
      .CLKGEN_TIMEOUT (CLKGEN_TIMEOUT)
   ) u_clkdiv_hs (
      .clk      (soc_clk_i),
      .rst_n    (soc_rstn_synced_i),
      .start    (start),
      .value_in (div_next),
      .abort    (~psel_i),
      .ack      (clkdiv_ack_i),
      .req      (hs_req),
      .done     (hs_done),
      .err      (hs_err),
      .value    (clkdiv_value_o),
      .applied  (hs_applied)
   );

   // Read mux; only reached from IDLE since handshake cycles are always writes.
   always_comb begin
      rdata = '0;
      if (hit_info) begin
         rdata = {16'(NB_PADS), INFO_VERSION};
      end else if (hit_scratch) begin
         rdata = scratch_q;
      end else if (hit_lock) begin
         rdata[0] = locked_q;
      end else if (hit_clkdiv) begin
         rdata[31]            = hs_req;
         rdata[DIV_WIDTH-1:0] = hs_applied;
      end else if (hit_bypass) begin
         rdata[1:0] = bypass_q;
      end else if (hit_pm) begin
         rdata = pm_rdata;
      end
   end

   assign prdata_o  = (access & ~pwrite_i & idle) ? rdata : 32'h0;
   assign pready_o  = ~hs_req & ~start;
   assign pslverr_o = access & ((idle & (decode_err | lock_err)) | hs_err);

   assign padmux_flat    = padmux_q;
   assign padmux_o       = padmux_flat[2*NB_PADS-1:0];
   assign clkdiv_req_o   = hs_req;
   assign fll_bypass_o   = bypass_q.src ? jtag_bypass_fll_i : bypass_q.val;
   assign locked_o       = locked_q;

endmodule

// File: tb/tb_chip_ctrl_apb_regfile.sv
// Bench for chip_ctrl_apb_regfile: APB vector table plus handshake, abort,
// reset and lock sequences, checked through an expectation queue.
module tb_chip_ctrl_apb_regfile;

   logic        clk;
   logic        rst_n;
   logic [11:0] paddr;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [95:0] padmux;
   logic        clkdiv_req;
   logic [7:0]  clkdiv_value;
   logic        clkdiv_ack;
   logic        jtag_bypass;
   logic        fll_bypass;
   logic        locked;

   chip_ctrl_apb_regfile dut (
      .soc_clk_i         (clk),
      .soc_rstn_synced_i (rst_n),
      .paddr_i           (paddr),
      .pprot_i           (pprot),
      .psel_i            (psel),
      .penable_i         (penable),
      .pwrite_i          (pwrite),
      .pwdata_i          (pwdata),
      .pstrb_i           (pstrb),
      .prdata_o          (prdata),
      .pready_o          (pready),
      .pslverr_o         (pslverr),
      .padmux_o          (padmux),
      .clkdiv_req_o      (clkdiv_req),
      .clkdiv_value_o    (clkdiv_value),
      .clkdiv_ack_i      (clkdiv_ack),
      .jtag_bypass_fll_i (jtag_bypass),
      .fll_bypass_o      (fll_bypass),
      .locked_o          (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } exp_t;

   typedef struct {
      string       name;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[15];
   int          total = 0;
   int          bad   = 0;

   // clock-generator model
   bit          ack_en = 1'b0;
   int          ack_at = 0;
   int          rc = 0;
   int          last_len = 0;
   logic [7:0]  exp_req_val = 8'h00;
   int          reqval_bad = 0;

   initial begin
      clkdiv_ack = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (clkdiv_req) begin
            rc++;
            if (clkdiv_value !== exp_req_val) reqval_bad++;
         end else begin
            if (rc != 0) last_len = rc;
            rc = 0;
         end
         clkdiv_ack = ack_en && clkdiv_req && (rc == ack_at);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic w, input logic [11:0] a,
                               input logic [31:0] d, input logic [31:0] r, input logic e);
      vec_t v;
      v.name = n; v.wr = w; v.addr = a; v.wdata = d; v.rdata = r; v.err = e;
      return v;
   endfunction

   task automatic apb(input string name, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_waits);
      exp_t        e;
      int          waits;
      bit          got;
      logic [31:0] rd;
      logic        er;
      e.name = name; e.rdata = exp_rd; e.err = exp_err; e.waits = exp_waits;
      sb.push_back(e);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      waits = 0; got = 1'b0; rd = '0; er = 1'b0;
      while (!got && waits <= 600) begin
         @(negedge clk);
         if (pready) begin
            got = 1'b1; rd = prdata; er = pslverr;
         end else begin
            waits++;
         end
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      e = sb.pop_front();
      if (!got) begin
         total++; bad++;
         $display("FAIL %s: pready stayed low for %0d cycles", e.name, waits);
      end else begin
         check({e.name, ".rdata"}, rd, e.rdata);
         check({e.name, ".err"}, 32'(er), 32'(e.err));
         check({e.name, ".waits"}, 32'(waits), 32'(e.waits));
      end
   endtask

   task automatic start_clkdiv_write(input logic [31:0] val);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C; pwdata = val;
      @(posedge clk); #1;
      penable = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = 4'hF; pprot = 3'b000; jtag_bypass = 1'b0;

      vecs[0]  = mk("rd_info",      1'b0, 12'h000, 32'h0,        32'h0030_0001, 1'b0);
      vecs[1]  = mk("rd_clkdiv",    1'b0, 12'h00C, 32'h0,        32'h0000_0001, 1'b0);
      vecs[2]  = mk("rd_scratch0",  1'b0, 12'h004, 32'h0,        32'h0,         1'b0);
      vecs[3]  = mk("wr_scratch",   1'b1, 12'h004, 32'h1234_5678, 32'h0,        1'b0);
      vecs[4]  = mk("rd_scratch1",  1'b0, 12'h004, 32'h0,        32'h1234_5678, 1'b0);
      vecs[5]  = mk("wr_pm2",       1'b1, 12'h108, 32'hFFFF_FFFF, 32'h0,        1'b0);
      vecs[6]  = mk("rd_pm2",       1'b0, 12'h108, 32'h0,        32'hFFFF_FFFF, 1'b0);
      vecs[7]  = mk("wr_pm3",       1'b1, 12'h10C, 32'h1,        32'h0,         1'b1);
      vecs[8]  = mk("rd_pm3",       1'b0, 12'h10C, 32'h0,        32'h0,         1'b1);
      vecs[9]  = mk("wr_pm0",       1'b1, 12'h100, 32'hA5A5_A5A5, 32'h0,        1'b0);
      vecs[10] = mk("rd_pm0",       1'b0, 12'h100, 32'h0,        32'hA5A5_A5A5, 1'b0);
      vecs[11] = mk("rd_bypass",    1'b0, 12'h010, 32'h0,        32'h0000_0002, 1'b0);
      vecs[12] = mk("rd_lock",      1'b0, 12'h008, 32'h0,        32'h0,         1'b0);
      vecs[13] = mk("rd_unmapped",  1'b0, 12'h200, 32'h0,        32'h0,         1'b1);
      vecs[14] = mk("rd_info_ub",   1'b0, 12'h003, 32'h0,        32'h0030_0001, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("rst.pready",  32'(pready), 32'h1);
      check("rst.pslverr", 32'(pslverr), 32'h0);
      check("rst.prdata",  prdata, 32'h0);
      check("rst.padmux0", padmux[31:0], 32'h0);
      check("rst.padmux2", padmux[95:64], 32'h0);
      check("rst.req",     32'(clkdiv_req), 32'h0);
      check("rst.divval",  32'(clkdiv_value), 32'h1);
      check("rst.locked",  32'(locked), 32'h0);
      check("rst.fll_j0",  32'(fll_bypass), 32'h0);
      jtag_bypass = 1'b1; #1;
      check("rst.fll_j1",  32'(fll_bypass), 32'h1);
      jtag_bypass = 1'b0; #1;

      for (int i = 0; i < 15; i++) begin
         apb(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err, 0);
      end
      check("pm.word0", padmux[31:0], 32'hA5A5_A5A5);
      check("pm.word1", padmux[63:32], 32'h0);
      check("pm.word2", padmux[95:64], 32'hFFFF_FFFF);

      // handshake acked on the 4th request cycle
      exp_req_val = 8'h05; ack_en = 1'b1; ack_at = 4;
      apb("cd_ok", 1'b1, 12'h00C, 32'h05, 32'h0, 1'b0, 5);
      @(negedge clk);
      check("cd_ok.req_len", 32'(last_len), 32'd4);
      check("cd_ok.value",   32'(clkdiv_value), 32'h05);
      apb("cd_ok_rd", 1'b0, 12'h00C, 32'h0, 32'h05, 1'b0, 0);

      // no ack: timeout reverts to the applied value
      exp_req_val = 8'h09; ack_en = 1'b0;
      apb("cd_to", 1'b1, 12'h00C, 32'h09, 32'h0, 1'b1, 256);
      @(negedge clk);
      check("cd_to.req_len", 32'(last_len), 32'd255);
      check("cd_to.value",   32'(clkdiv_value), 32'h05);
      apb("cd_to_rd", 1'b0, 12'h00C, 32'h0, 32'h05, 1'b0, 0);

      // ack on the terminal count wins
      ack_en = 1'b1; ack_at = 255;
      apb("cd_term", 1'b1, 12'h00C, 32'h09, 32'h0, 1'b0, 256);
      @(negedge clk);
      check("cd_term.req_len", 32'(last_len), 32'd255);
      check("cd_term.value",   32'(clkdiv_value), 32'h09);
      apb("cd_term_rd", 1'b0, 12'h00C, 32'h0, 32'h09, 1'b0, 0);
      check("cd.req_value_stable", 32'(reqval_bad), 32'd0);
      ack_en = 1'b0;

      apb("byp_wr", 1'b1, 12'h010, 32'h1, 32'h0, 1'b0, 0);
      jtag_bypass = 1'b0; #1;
      check("byp.val_j0", 32'(fll_bypass), 32'h1);
      jtag_bypass = 1'b1; #1;
      check("byp.val_j1", 32'(fll_bypass), 32'h1);
      jtag_bypass = 1'b0;
      apb("byp_rd", 1'b0, 12'h010, 32'h0, 32'h1, 1'b0, 0);

      // psel dropped mid-request
      exp_req_val = 8'h22;
      start_clkdiv_write(32'h22);
      repeat (3) @(negedge clk);
      check("abort.req_before", 32'(clkdiv_req), 32'h1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort.req_after", 32'(clkdiv_req), 32'h0);
      check("abort.value",     32'(clkdiv_value), 32'h09);
      check("abort.pready",    32'(pready), 32'h1);
      apb("abort_rd", 1'b0, 12'h00C, 32'h0, 32'h09, 1'b0, 0);

      // reset while a request is outstanding
      exp_req_val = 8'h33;
      start_clkdiv_write(32'h33);
      repeat (3) @(negedge clk);
      check("rstmid.req_before", 32'(clkdiv_req), 32'h1);
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      #1;
      check("rstmid.req",   32'(clkdiv_req), 32'h0);
      check("rstmid.value", 32'(clkdiv_value), 32'h1);
      @(negedge clk) rst_n = 1'b1;
      apb("rstmid_scratch", 1'b0, 12'h004, 32'h0, 32'h0, 1'b0, 0);
      check("rstmid.padmux2", padmux[95:64], 32'h0);

      // lock behaviour
      apb("lk_pm_pre", 1'b1, 12'h100, 32'h3, 32'h0, 1'b0, 0);
      apb("lk_set",    1'b1, 12'h008, 32'h1, 32'h0, 1'b0, 0);
      check("lk.locked", 32'(locked), 32'h1);
      apb("lk_pm",     1'b1, 12'h100, 32'h5, 32'h0, 1'b1, 0);
      check("lk.padmux0", padmux[31:0], 32'h3);
      apb("lk_cd",     1'b1, 12'h00C, 32'h7, 32'h0, 1'b1, 0);
      check("lk.divval", 32'(clkdiv_value), 32'h1);
      apb("lk_byp",    1'b1, 12'h010, 32'h1, 32'h0, 1'b1, 0);
      apb("lk_byp_rd", 1'b0, 12'h010, 32'h0, 32'h2, 1'b0, 0);
      apb("lk_scr_wr", 1'b1, 12'h004, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
      apb("lk_scr_rd", 1'b0, 12'h004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
      apb("lk_rd",     1'b0, 12'h008, 32'h0, 32'h1, 1'b0, 0);

      @(negedge clk) rst_n = 1'b0;
      #1;
      check("final.locked", 32'(locked), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chip_ctrl_apb_regfile.md
Name: chip_ctrl_apb_regfile

Overview:
APB3 slave sitting directly downstream of the SoC domain's chip-control APB master port. It holds platform-dependent control state:
- pad-mux selections
- a peripheral clock-divider setting, handed to the clock generator via a req/ack handshake with timeout
- FLL-bypass source selection
- a sticky configuration lock

All outputs are consumed by the pad frame and the clock generation logic.

Parameters:
NB_PADS, 48, number of muxable pads, 2 select bits each
APB_ADDR_WIDTH, 12, local offset width; paddr_i upper bits are already decoded away
DIV_WIDTH, 8, clock-divider value width
DIV_RESET, 1, divider value applied after reset
CLKGEN_TIMEOUT, 255, max cycles spent waiting for clkdiv_ack_i (>=1)

Ports:
soc_clk_i  in  1  SoC clock
soc_rstn_synced_i  in  1  asynchronous active-low reset
paddr_i  in  APB_ADDR_WIDTH  APB address (byte)
pprot_i  in  3  APB protection, ignored
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
padmux_o  out  2*NB_PADS  pad select, pad i at bits [2i+1:2i]
clkdiv_req_o  out  1  divider update request
clkdiv_value_o  out  DIV_WIDTH  divider value, requested or applied
clkdiv_ack_i  in  1  clock generator acknowledge
jtag_bypass_fll_i  in  1  FLL-bypass bit from the JTAG TAP
fll_bypass_o  out  1  FLL-bypass control
locked_o  out  1  configuration lock status

Behaviour:
- Clocking and reset: one clock, soc_clk_i. Reset soc_rstn_synced_i is asynchronous, active-low.
- Reset values:
  - prdata_o=0, pslverr_o=0, pready_o=1 (FSM in IDLE)
  - padmux_o=0, clkdiv_req_o=0, clkdiv_value_o=DIV_RESET
  - fll_bypass_o=jtag_bypass_fll_i (BYPASS.SRC=1), locked_o=0
- Register map (word-aligned; paddr_i[1:0] ignored):
  - 0x000 INFO RO = {NB_PADS[15:0], 16'h0001}.
  - 0x004 SCRATCH RW 32b. Reset 0. Never locked.
  - 0x008 LOCK: bit0 write-1-sets. Cleared only by reset. Drives locked_o.
  - 0x00C CLKDIV:
    - Write launches the handshake with the new value.
    - Read = {busy, 0, applied value}, where busy is bit31 and is 1 while in REQ.
  - 0x010 BYPASS: bit0 VAL (reset 0), bit1 SRC (reset 1). fll_bypass_o = SRC ? jtag_bypass_fll_i : VAL (combinational).
  - 0x100 + 4k PADMUX word k, k < ceil(NB_PADS/16): 16 pads x 2b. Bits for pads >= NB_PADS read 0 and are not writable.
  - Any other offset: read 0 with pslverr=1; write has no effect with pslverr=1.
- Lock: while locked_o=1, writes to CLKDIV, BYPASS, PADMUX and LOCK are dropped with pslverr=1. Reads and SCRATCH writes are unaffected.
- APB FSM states:
  - IDLE: pready_o=1. Zero-wait-state completion in the first ACCESS cycle (psel&penable) for every transfer except an unlocked CLKDIV write.
    - Register update lands at that cycle's clock edge.
    - prdata_o is combinational from the registers during ACCESS of a read, otherwise 0.
    - An unlocked CLKDIV write with pready_o=0 latches the value and moves to REQ.
  - REQ: clkdiv_req_o=1 and clkdiv_value_o=the new value, stable throughout; pready_o=0.
    - A timeout counter counts cycles in REQ.
    - clkdiv_ack_i sampled 1: go to DONE_OK.
    - Counter reaches CLKGEN_TIMEOUT with no ack: go to DONE_ERR.
    - Ack in the same cycle as the terminal count: ack wins.
  - DONE_OK: pready_o=1, pslverr_o=0, req=0. The applied value is updated at the entry edge. Returns to IDLE.
  - DONE_ERR: pready_o=1, pslverr_o=1, req=0. clkdiv_value_o reverts to the previously applied value. Returns to IDLE.
  - Latency: the first ACCESS cycle is T. req rises at T+1. Ack is sampled at cycle A. pready_o=1 at A+1.
- clkdiv_ack_i outside REQ is ignored.
- psel_i dropping in REQ or DONE_* (protocol violation): abort to IDLE, req=0, applied value unchanged.
- Reset mid-handshake: req drops immediately, value returns to DIV_RESET.
- pslverr_o is 0 whenever pready_o=0 or no transfer is in ACCESS.

Optional Feature:
CHIP_CTRL_APB_PSTRB_EN
- Defined: writes honour pstrb_i per byte. CLKDIV launches a handshake only if byte 0 is strobed; otherwise the write is a no-op OK. LOCK requires byte 0.
- Undefined: pstrb_i is ignored and every write is a full 32-bit write.

Decomposition:
- Package chip_ctrl_pkg: register offset localparams, padmux_sel_e (2b enum: GPIO/ALT1/ALT2/ALT3), apb_fsm_e state enum, INFO version constant.
- Sub-module chip_ctrl_clkdiv_hs: contains REQ/DONE sequencing, the timeout counter and the applied-value register. Interface: start/value in, done/err out.

Test Plan:
- Reset, then read 0x000 -> prdata=0x00300001 (NB_PADS=48), pslverr=0, zero wait. Read 0x00C -> 0x00000001.
- Write 0x00C=0x05; ack asserted 3 cycles after req rises -> req high for exactly 4 cycles, pready at ack+1, read 0x00C -> 0x05.
- Write 0x00C=0x09 with ack never asserted (CLKGEN_TIMEOUT=255) -> pslverr=1 after 255 REQ cycles, clkdiv_value_o returns to 0x05. Also drive ack on the terminal cycle -> OK response, value 0x09.
- Write PADMUX 0x108=0xFFFFFFFF (pads 32-47) -> padmux_o[95:64] all 1s. Write 0x10C -> pslverr=1.
- BYPASS: SRC=1, toggle jtag_bypass_fll_i -> fll_bypass_o follows. Write 0x010=0x1 -> fll_bypass_o=1 regardless of JTAG.
- Write LOCK=1, then PADMUX 0x100=0x5 -> pslverr=1, padmux unchanged. SCRATCH write 0xDEADBEEF reads back. Assert reset -> locked_o=0.
